// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core and its receiver.
// UART_PARITY_EN adds the even-parity state to both FSM encodings.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, falling-edge start detect, mid-bit sampling.
// With UART_PARITY_EN defined the even parity bit is checked before the stop bit.
//
// state     | meaning
// RX_IDLE   | waiting for a high->low edge on the synchronised line
// RX_START  | half-bit wait, then confirm the start bit is still low
// RX_DATA   | sample 8 data bits LSB first, one bit period apart
// RX_PARITY | sample the parity bit (UART_PARITY_EN only)
// RX_STOP   | sample the stop bit, report byte or frame error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err
`ifdef UART_PARITY_EN
  ,
  output logic                 rx_parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

  rx_state_t            rx_state, rx_next;
  logic [1:0]           sync_q;
  logic                 line_prev;
  logic                 rx_line;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;
  logic                 stop_hit;
`ifdef UART_PARITY_EN
  logic                 par_bit;
`endif

  assign rx_line = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (line_prev && !rx_line) rx_next = RX_START;
      RX_START: if (tick) rx_next = rx_line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == LAST_BIT)
`ifdef UART_PARITY_EN
                  rx_next = RX_PARITY;
      RX_PARITY: if (tick) rx_next = RX_STOP;
`else
                  rx_next = RX_STOP;
`endif
      RX_STOP:  if (tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    tick     = (rx_state != RX_IDLE) && (cnt == '0);
    stop_hit = (rx_state == RX_STOP) && (cnt == '0);
  end

  // The bit timer is preloaded with the half-bit count while idle so the
  // first sample lands mid start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      line_prev    <= 1'b1;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      sync_q       <= {sync_q[0], rxd};
      line_prev    <= rx_line;
      rx_valid     <= stop_hit && rx_line;
      rx_frame_err <= stop_hit && !rx_line;
`ifdef UART_PARITY_EN
      rx_parity_err <= stop_hit && (par_bit != ^shift);
      if (rx_state == RX_PARITY && tick) par_bit <= rx_line;
`endif
      if (stop_hit && rx_line) rx_data <= shift;
      if (rx_state == RX_IDLE) begin
        cnt     <= HALF_LAST;
        bit_idx <= '0;
      end else if (tick) begin
        cnt <= BIT_LAST;
        if (rx_state == RX_DATA) begin
          shift   <= {rx_line, shift[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART top: TX FSM here, receiver in uart_rx.
// UART_PARITY_EN switches framing from 8N1 to 8E1 and adds rx_parity_err.
//
// state     | meaning
// TX_IDLE   | tx_ready high, txd high, waiting for tx_valid
// TX_START  | driving the start bit (low)
// TX_DATA   | driving data bits LSB first
// TX_PARITY | driving the even parity bit (UART_PARITY_EN only)
// TX_STOP   | driving the stop bit (high)
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err
`ifdef UART_PARITY_EN
  ,
  output logic                 rx_parity_err
`endif
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  tx_state_t            tx_state, tx_next;
  logic [CNT_W-1:0]     tx_cnt;
  logic [IDX_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 tx_done;

  assign tx_done = (tx_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_valid) tx_next = TX_START;
      TX_START: if (tx_done) tx_next = TX_DATA;
      TX_DATA:  if (tx_done && tx_bit == LAST_BIT)
`ifdef UART_PARITY_EN
                  tx_next = TX_PARITY;
      TX_PARITY: if (tx_done) tx_next = TX_STOP;
`else
                  tx_next = TX_STOP;
`endif
      TX_STOP:  if (tx_done) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = 1'b0;
    txd      = 1'b1;
    case (tx_state)
      TX_IDLE:   tx_ready = 1'b1;
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_byte[tx_bit];
`ifdef UART_PARITY_EN
      TX_PARITY: txd = ^tx_byte;
`endif
      default:   ;
    endcase
  end

  // The byte only loads while idle, so the client may change tx_data freely mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_byte <= '0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt <= BIT_LAST;
      tx_bit <= '0;
      if (tx_valid) tx_byte <= tx_data;
    end else if (tx_done) begin
      tx_cnt <= BIT_LAST;
      if (tx_state == TX_DATA) tx_bit <= tx_bit + 1'b1;
    end else begin
      tx_cnt <= tx_cnt - 1'b1;
    end
  end

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
`ifdef UART_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: table-driven RX frames, TX waveform checks,
// loopback, glitch, reset-abort and randomized full-duplex traffic.
module tb_uart_core;

  localparam int CPB = 50_000_000 / 115200;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? 11 : 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, txd, rxd;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err;
  logic       loop_en = 1'b0;
  logic       rxd_drv = 1'b1;
`ifdef UART_PARITY_EN
  logic       rx_parity_err;
  int         perr_cnt = 0;
`endif

  assign rxd = loop_en ? txd : rxd_drv;

  always #10 clk = ~clk;

  uart_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .txd          (txd),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
`ifdef UART_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Receive-side monitor: records every reported byte and error pulse.
  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  logic [7:0] got_mem [64];

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (valid_cnt < 64) got_mem[valid_cnt] = rx_data;
        valid_cnt++;
      end
      if (rx_frame_err) ferr_cnt++;
`ifdef UART_PARITY_EN
      if (rx_parity_err) perr_cnt++;
`endif
    end
  end

  // Line level of bit i of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i, input logic stop);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (PAR && i == 9) return ^b;
    return stop;
  endfunction

  task automatic send_byte(input logic [7:0] b, input string tag);
    int t = 0;
    @(negedge clk);
    while (!tx_ready && t < 20 * CPB) begin
      @(negedge clk);
      t++;
    end
    check({tag, " ready"}, tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = ~b;
  endtask

  task automatic tx_check(input logic [7:0] b, input string tag);
    int busy = 0;
    int good [NB];
    for (int i = 0; i < NB; i++) good[i] = 0;
    send_byte(b, tag);
    while (!tx_ready && busy < NB * CPB + 10) begin
      if (busy / CPB < NB && txd === frame_bit(b, busy / CPB, 1'b1)) good[busy / CPB]++;
      if (busy == 3 * CPB) tx_valid = 1'b1;
      if (busy == 3 * CPB + 1) tx_valid = 1'b0;
      @(posedge clk);
      #1;
      busy++;
    end
    for (int i = 0; i < NB; i++) check($sformatf("%s bit%0d cycles", tag, i), good[i], CPB);
    check({tag, " busy cycles"}, busy, NB * CPB);
    check({tag, " idle txd"}, txd, 1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < NB; i++) begin
      rxd_drv = frame_bit(b, i, stop);
      repeat (CPB) @(posedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } rx_vec_t;

  rx_vec_t    vecs [4];
  int         v0, f0;
  logic [7:0] tb_b, rb_b;

  initial begin
    vecs[0] = '{8'h3C, 1'b0, 0, 1, 8'h00};
    vecs[1] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[2] = '{8'h3C, 1'b0, 0, 1, 8'h81};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset txd", txd, 1);
    check("reset tx_ready", tx_ready, 1);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_frame_err", rx_frame_err, 0);
    check("reset rx_data", rx_data, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v0 = valid_cnt;
      f0 = ferr_cnt;
      drive_frame(vecs[k].data, vecs[k].stop);
      repeat (CPB) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d rx_valid pulses", k), valid_cnt - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d frame_err pulses", k), ferr_cnt - f0, vecs[k].exp_ferr);
      check($sformatf("vec%0d rx_data", k), rx_data, vecs[k].exp_data);
    end

    tx_check(8'hA5, "tx A5");

    loop_en = 1'b1;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_byte(8'h00, "loop 00");
    send_byte(8'hFF, "loop FF");
    send_byte(8'h5A, "loop 5A");
    repeat (NB * CPB + 2 * CPB) @(posedge clk);
    @(negedge clk);
    check("loop rx_valid pulses", valid_cnt - v0, 3);
    check("loop frame_err pulses", ferr_cnt - f0, 0);
    check("loop byte0", got_mem[v0], 8'h00);
    check("loop byte1", got_mem[v0 + 1], 8'hFF);
    check("loop byte2", got_mem[v0 + 2], 8'h5A);
`ifdef UART_PARITY_EN
    check("loop parity_err pulses", perr_cnt, 0);
`endif
    loop_en = 1'b0;

    @(negedge clk);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rxd_drv = 1'b0;
    repeat (100) @(posedge clk);
    rxd_drv = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    check("glitch rx_valid pulses", valid_cnt - v0, 0);
    check("glitch frame_err pulses", ferr_cnt - f0, 0);
    drive_frame(8'hC5, 1'b1);
    repeat (CPB) @(posedge clk);
    @(negedge clk);
    check("post-glitch rx_valid pulses", valid_cnt - v0, 1);
    check("post-glitch rx_data", rx_data, 8'hC5);

    send_byte(8'h33, "abort");
    repeat (3 * CPB + 7) @(posedge clk);
    @(negedge clk);
    check("mid-frame txd low", txd, 0);
    rst_n = 1'b0;
    #1;
    check("abort txd", txd, 1);
    check("abort tx_ready", tx_ready, 1);
    check("abort rx_data", rx_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tx_check(8'h96, "after reset");

    for (int k = 0; k < 3; k++) begin
      tb_b = 8'($urandom);
      rb_b = 8'($urandom);
      v0 = valid_cnt;
      f0 = ferr_cnt;
      fork
        tx_check(tb_b, $sformatf("duplex%0d tx", k));
        begin
          @(negedge clk);
          drive_frame(rb_b, 1'b1);
        end
      join
      repeat (CPB) @(posedge clk);
      @(negedge clk);
      check($sformatf("duplex%0d rx_valid pulses", k), valid_cnt - v0, 1);
      check($sformatf("duplex%0d frame_err pulses", k), ferr_cnt - f0, 0);
      check($sformatf("duplex%0d rx_data", k), rx_data, rb_b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
